// File: rtl/video_timing_gen.sv
// Raster timing generator: counts pixel clocks into sync, data-enable and frame
// markers, and requests pixel coordinates one cycle ahead of the active window.
module video_timing_gen #(
  parameter logic [10:0] H_SYNC   = 11'd40,
  parameter logic [10:0] H_BACK   = 11'd220,
  parameter logic [10:0] H_DISP   = 11'd1280,
  parameter logic [10:0] H_FRONT  = 11'd110,
  parameter logic [10:0] V_SYNC   = 11'd5,
  parameter logic [10:0] V_BACK   = 11'd20,
  parameter logic [10:0] V_DISP   = 11'd720,
  parameter logic [10:0] V_FRONT  = 11'd5,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);

  localparam int unsigned CNT_W = 11;

  localparam logic [CNT_W-1:0] H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [CNT_W-1:0] V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [CNT_W-1:0] H_LAST   = H_TOTAL - CNT_W'(1);
  localparam logic [CNT_W-1:0] V_LAST   = V_TOTAL - CNT_W'(1);
  localparam logic [CNT_W-1:0] H_START  = H_SYNC + H_BACK;
  localparam logic [CNT_W-1:0] V_START  = V_SYNC + V_BACK;
  // Requests lead the display window by one pixel to cover the source latency
  localparam logic [CNT_W-1:0] REQ_H_LO = H_START - CNT_W'(1);
  localparam logic [CNT_W-1:0] REQ_H_HI = H_START + H_DISP - CNT_W'(1);
  localparam logic [CNT_W-1:0] REQ_V_LO = V_START;
  localparam logic [CNT_W-1:0] REQ_V_HI = V_START + V_DISP;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_in;
  logic             v_in;

  // Pixel and line counters; reset aborts the frame in place
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Request window and coordinates, held at zero outside the window
  always_comb begin
    h_in       = (h_cnt >= REQ_H_LO) && (h_cnt < REQ_H_HI);
    v_in       = (v_cnt >= REQ_V_LO) && (v_cnt < REQ_V_HI);
    data_req   = h_in && v_in;
    pixel_xpos = '0;
    pixel_ypos = '0;
    if (data_req) begin
      pixel_xpos = h_cnt - REQ_H_LO;
      pixel_ypos = v_cnt - REQ_V_LO;
    end
  end

  // Sync, enable and frame marker all lag the counters by one cycle
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      video_hs    <= ~SYNC_POL;
      video_vs    <= ~SYNC_POL;
      video_de    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= (h_cnt < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_vs    <= (v_cnt < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_de    <= data_req;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign video_rgb = video_de ? pixel_data : '0;

endmodule
